demux1_2_32bit_buf: RTL and testbench

- Inverse of the pipeline's 2:1 data select: takes one 32-bit producer stream and steers each word to output channel A (code=0) or channel B (code=1).
- Each channel has its own small FIFO, so the two consumers (e.g. two downstream pipeline stages or writeback paths) can stall independently.
- Valid/ready handshakes on every side.
- Per-channel delivered-word counters for debug and performance monitoring.

---
 rtl/demux1_2_32bit_buf.sv | 142 ++++++++++++++
 tb/tb_demux1_2_32bit_buf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_32bit_buf.sv
// rtl/demux1_2_32bit_buf.sv - 1:2 stream demux with an independent FIFO and delivered-word counter per channel
//
// Ports (demux1_2_32bit_buf):
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     producer handshake; code selects the channel (0 -> A, 1 -> B), din is the word
//   a_valid/a_ready/a_data channel A head word and consumer handshake
//   b_valid/b_ready/b_data channel B head word and consumer handshake
//   a_cnt, b_cnt          words delivered (popped) per channel, wrapping at 2^CNT_W
//
// Ports (demux1_2_32bit_buf_fifo):
//   clk, rst_n            clock and asynchronous active-low reset
//   push, din             write strobe (already gated by !full) and write data
//   valid, ready, data    head word, consumer handshake, head data
//   full                  channel cannot take another word this cycle
//   cnt                   delivered-word counter

module demux1_2_32bit_buf_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic [CNT_W-1:0] cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             pop;

    // Head word comes straight from storage so there is never a din -> data path.
    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign data  = mem[rd_ptr];
    assign pop   = valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

module demux1_2_32bit_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             code,
    input  logic [WIDTH-1:0] din,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    logic a_full;
    logic b_full;
    logic push_a;
    logic push_b;

    // Ready looks only at the selected channel's registered occupancy; a pop in
    // the same cycle does not open a slot, which keeps in_ready off the
    // consumer-ready paths.
    assign in_ready = code ? !b_full : !a_full;
    assign push_a   = in_valid & in_ready & !code;
    assign push_b   = in_valid & in_ready &  code;

    demux1_2_32bit_buf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_a),
        .din   (din),
        .valid (a_valid),
        .ready (a_ready),
        .data  (a_data),
        .full  (a_full),
        .cnt   (a_cnt)
    );

    demux1_2_32bit_buf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_b),
        .din   (din),
        .valid (b_valid),
        .ready (b_ready),
        .data  (b_data),
        .full  (b_full),
        .cnt   (b_cnt)
    );

endmodule

// File: tb/tb_demux1_2_32bit_buf.sv
// tb/tb_demux1_2_32bit_buf.sv - self-checking bench for demux1_2_32bit_buf

module tb_demux1_2_32bit_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        code;
    logic [31:0] din;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
    logic [15:0] a_cnt;
    logic [15:0] b_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          m_acnt;
    int          m_bcnt;

    demux1_2_32bit_buf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .code     (code),
        .din      (din),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_cnt(input int c);
        return c[15:0];
    endfunction

    task automatic drive(input logic iv, input logic c, input logic [31:0] d,
                         input logic ar, input logic br);
        in_valid = iv;
        code     = c;
        din      = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    // Advance one clock and update the reference model from the inputs and
    // the model's own state as they stood just before the edge.
    task automatic clk_edge();
        bit pa;
        bit pb;
        bit acc;
        @(posedge clk);
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            m_acnt = 0;
            m_bcnt = 0;
        end else begin
            pa  = a_ready && (qa.size() > 0);
            pb  = b_ready && (qb.size() > 0);
            acc = in_valid && (code ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
            if (pa) begin
                void'(qa.pop_front());
                m_acnt++;
            end
            if (pb) begin
                void'(qb.pop_front());
                m_bcnt++;
            end
            if (acc) begin
                if (code) qb.push_back(din);
                else      qa.push_back(din);
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        clk_edge();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
        #2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got a=%0b b=%0b exp 0/0", a_valid, b_valid); end
        total++; if (a_cnt !== 16'h0 || b_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got a=%h b=%h exp 0/0", a_cnt, b_cnt); end
        total++; if (a_data !== 32'h0 || b_data !== 32'h0) begin bad++; $display("FAIL reset_data got a=%h b=%h exp 0/0", a_data, b_data); end
        clk_edge();
        rst_n = 1'b1;
        #1;
        clk_edge();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        total++; if (a_valid !== 1'b1 || a_data !== 32'h1234_5678) begin bad++; $display("FAIL reset_release_word got v=%0b d=%h exp v=1 d=12345678", a_valid, a_data); end
    endtask

    task automatic test_alternate();
        logic [31:0] w;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            w = 32'hA000_0001 + 32'(i);
            drive(1'b1, i[0], w, 1'b1, 1'b1);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL alt_in_ready[%0d] got=%0b exp=1", i, in_ready); end
            clk_edge();
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            #1;
            if (i[0]) begin
                total++; if (b_valid !== 1'b1 || b_data !== w) begin bad++; $display("FAIL alt_b[%0d] got v=%0b d=%h exp v=1 d=%h", i, b_valid, b_data, w); end
            end else begin
                total++; if (a_valid !== 1'b1 || a_data !== w) begin bad++; $display("FAIL alt_a[%0d] got v=%0b d=%h exp v=1 d=%h", i, a_valid, a_data, w); end
            end
        end
        clk_edge();
        clk_edge();
        total++; if (a_cnt !== 16'd2 || b_cnt !== 16'd2) begin bad++; $display("FAIL alt_cnt got a=%0d b=%0d exp 2/2", a_cnt, b_cnt); end
        total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL alt_drained got a=%0b b=%0b exp 0/0", a_valid, b_valid); end
    endtask

    task automatic test_full_a();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'hC000_0000 + 32'(i), 1'b0, 1'b1);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_push_ready[%0d] got=%0b exp=1", i, in_ready); end
            clk_edge();
        end
        drive(1'b1, 1'b0, 32'hC000_0002, 1'b0, 1'b1);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_third_ready got=%0b exp=0", in_ready); end
        drive(1'b1, 1'b1, 32'hBBBB_0000, 1'b0, 1'b0);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_other_ready got=%0b exp=1", in_ready); end
        clk_edge();
        drive(1'b1, 1'b0, 32'hC000_0002, 1'b1, 1'b1);
        #1;
        total++; if (b_valid !== 1'b1 || b_data !== 32'hBBBB_0000) begin bad++; $display("FAIL full_b_word got v=%0b d=%h exp v=1 d=bbbb0000", b_valid, b_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_no_bypass got=%0b exp=0", in_ready); end
        total++; if (a_data !== 32'hC000_0000) begin bad++; $display("FAIL full_head0 got=%h exp=c0000000", a_data); end
        clk_edge();
        drive(1'b1, 1'b0, 32'hC000_0002, 1'b0, 1'b1);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_next_accept got=%0b exp=1", in_ready); end
        clk_edge();
        for (int i = 1; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            #1;
            total++; if (a_valid !== 1'b1 || a_data !== 32'hC000_0000 + 32'(i)) begin bad++; $display("FAIL full_order[%0d] got v=%0b d=%h exp v=1 d=%h", i, a_valid, a_data, 32'hC000_0000 + 32'(i)); end
            clk_edge();
        end
        total++; if (a_valid !== 1'b0 || a_cnt !== 16'd3) begin bad++; $display("FAIL full_end got v=%0b cnt=%0d exp v=0 cnt=3", a_valid, a_cnt); end
    endtask

    task automatic test_cnt_wrap();
        apply_reset();
        drive(1'b1, 1'b0, 32'h5A5A_0001, 1'b1, 1'b1);
        clk_edge();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b1, $urandom, 1'b1, 1'b1);
            clk_edge();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        clk_edge();
        total++; if (b_cnt !== 16'hFFFF || b_valid !== 1'b0) begin bad++; $display("FAIL wrap_preload got cnt=%h v=%0b exp cnt=ffff v=0", b_cnt, b_valid); end
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL wrap_a_before got=%0d exp=1", a_cnt); end
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        clk_edge();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        clk_edge();
        total++; if (b_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_b got=%h exp=0000", b_cnt); end
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL wrap_a_after got=%0d exp=1", a_cnt); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
            clk_edge();
        end
        drive(1'b1, 1'b0, 32'hE000_0009, 1'b1, 1'b0);
        #1;
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL mid_filled got=%0b exp=1", a_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (a_valid !== 1'b0 || a_data !== 32'h0 || a_cnt !== 16'h0) begin bad++; $display("FAIL mid_async got v=%0b d=%h cnt=%0d exp 0/0/0", a_valid, a_data, a_cnt); end
        clk_edge();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        clk_edge();
        total++; if (a_valid !== 1'b0 || a_cnt !== 16'h0) begin bad++; $display("FAIL mid_no_stale got v=%0b cnt=%0d exp 0/0", a_valid, a_cnt); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0));
            #1;
            total++;
            if (in_ready !== (code ? (qb.size() < DEPTH) : (qa.size() < DEPTH))) begin
                bad++; $display("FAIL rnd_in_ready[%0d] got=%0b", i, in_ready);
            end
            total++;
            if (a_valid !== (qa.size() != 0) || (qa.size() != 0 && a_data !== qa[0])) begin
                bad++; $display("FAIL rnd_a[%0d] got v=%0b d=%h exp v=%0b d=%h", i, a_valid, a_data, qa.size() != 0, (qa.size() != 0) ? qa[0] : 32'h0);
            end
            total++;
            if (b_valid !== (qb.size() != 0) || (qb.size() != 0 && b_data !== qb[0])) begin
                bad++; $display("FAIL rnd_b[%0d] got v=%0b d=%h exp v=%0b d=%h", i, b_valid, b_data, qb.size() != 0, (qb.size() != 0) ? qb[0] : 32'h0);
            end
            total++;
            if (a_cnt !== exp_cnt(m_acnt) || b_cnt !== exp_cnt(m_bcnt)) begin
                bad++; $display("FAIL rnd_cnt[%0d] got a=%0d b=%0d exp a=%0d b=%0d", i, a_cnt, b_cnt, exp_cnt(m_acnt), exp_cnt(m_bcnt));
            end
            clk_edge();
        end
    endtask

    initial begin
        qa.delete();
        qb.delete();
        m_acnt = 0;
        m_bcnt = 0;
        test_reset();
        test_alternate();
        test_full_a();
        test_reset_mid();
        test_random();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
